// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Common data bus arbiter. The ALU and LSB result producers each
//            feed a small FIFO (with a zero-latency bypass when the FIFO is
//            empty). A round-robin arbiter registers at most one result per
//            cycle onto the CDB. It also provides full flags for backpressure,
//            a sticky overflow flag and a saturating conflict counter.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int ROB_ID_W   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_PTR_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rob_clear,
    input  logic                alu_ready,
    input  logic [ROB_ID_W-1:0] alu_rob_id,
    input  logic [31:0]         alu_value,
    input  logic                lsb_ready,
    input  logic [ROB_ID_W-1:0] lsb_rob_id,
    input  logic [31:0]         lsb_value,
    output logic                alu_full,
    output logic                lsb_full,
    output logic                cdb_valid,
    output logic [ROB_ID_W-1:0] cdb_rob_id,
    output logic [31:0]         cdb_value,
    output logic                cdb_src,
    output logic                overflow,
    output logic [15:0]         conflict_cnt
);

    // Occupancy counters need one extra bit to represent a completely full FIFO.
    localparam int                 c_CNT_W     = FIFO_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_FULL  = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_HIGH  = c_CNT_W'(FIFO_DEPTH - 1);
    localparam logic               c_SRC_ALU   = 1'b0;
    localparam logic               c_SRC_LSB   = 1'b1;

    // Per-source views of the producer inputs; index 0 = ALU, 1 = LSB.
    logic [1:0]          w_in_ready;
    logic [ROB_ID_W-1:0] w_in_id  [2];
    logic [31:0]         w_in_val [2];

    // Per-source candidates and arbitration results.
    logic [1:0]          w_cand;
    logic [ROB_ID_W-1:0] w_cand_id  [2];
    logic [31:0]         w_cand_val [2];
    logic [1:0]          w_grant;
    logic [1:0]          w_dropped;
    logic [1:0]          w_full;
    logic                w_conflict;
    logic                w_any_grant;
    logic                w_grant_src;

    // Output and arbiter state.
    logic                r_cdb_valid;
    logic [ROB_ID_W-1:0] r_cdb_rob_id;
    logic [31:0]         r_cdb_value;
    logic                r_cdb_src;
    logic                r_rr_last;
    logic                r_overflow;
    logic [15:0]         r_conflict_cnt;

    assign w_in_ready  = {lsb_ready, alu_ready};
    assign w_in_id[0]  = alu_rob_id;
    assign w_in_id[1]  = lsb_rob_id;
    assign w_in_val[0] = alu_value;
    assign w_in_val[1] = lsb_value;

    // ------------------------------------------------------------------------
    // One FIFO per source. The candidate is the FIFO head when something is
    // queued, otherwise the incoming entry is offered directly (bypass) so an
    // idle bus costs only the single output-register cycle.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < 2; i++) begin : g_src
        logic [ROB_ID_W-1:0]   r_mem_id  [FIFO_DEPTH];
        logic [31:0]           r_mem_val [FIFO_DEPTH];
        logic [FIFO_PTR_W-1:0] r_rd_ptr;
        logic [FIFO_PTR_W-1:0] r_wr_ptr;
        logic [c_CNT_W-1:0]    r_cnt;
        logic                  r_full;
        logic                  w_empty;
        logic                  w_pop;
        logic                  w_push;
        logic                  w_drop;
        logic                  w_wr;
        logic [c_CNT_W-1:0]    w_cnt_next;

        assign w_empty       = (r_cnt == '0);
        assign w_cand[i]     = !w_empty || w_in_ready[i];
        assign w_cand_id[i]  = w_empty ? w_in_id[i]  : r_mem_id[r_rd_ptr];
        assign w_cand_val[i] = w_empty ? w_in_val[i] : r_mem_val[r_rd_ptr];

        // A bypassed grant consumes the incoming entry, so it is not stored.
        assign w_pop  = w_grant[i] && !w_empty;
        assign w_push = w_in_ready[i] && !(w_grant[i] && w_empty);
        assign w_drop = w_push && (r_cnt == c_CNT_FULL) && !w_pop;
        assign w_wr   = w_push && !w_drop;

        assign w_dropped[i] = w_drop;
        assign w_full[i]    = r_full;

        // Next occupancy; a simultaneous push and pop cancel out.
        always_comb begin
            w_cnt_next = r_cnt;
            if (w_wr && !w_pop) begin
                w_cnt_next = r_cnt + 1'b1;
            end else if (!w_wr && w_pop) begin
                w_cnt_next = r_cnt - 1'b1;
            end
        end

        // Pointer, occupancy and lookahead full-flag state for this source.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_cnt    <= '0;
                r_full   <= 1'b0;
            end else if (rob_clear) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_cnt    <= '0;
                r_full   <= 1'b0;
            end else if (rdy) begin
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_wr) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                r_cnt  <= w_cnt_next;
                // One slot of slack is kept for a result already in flight.
                r_full <= (w_cnt_next >= c_CNT_HIGH);
            end
        end

        // Entry storage; contents are only meaningful while counted.
        always_ff @(posedge clk) begin
            if (rdy && !rob_clear && w_wr) begin
                r_mem_id[r_wr_ptr]  <= w_in_id[i];
                r_mem_val[r_wr_ptr] <= w_in_val[i];
            end
        end
    end

    // Round-robin grant: on a conflict the source that did not win last time
    // is chosen; a lone candidate is always granted.
    always_comb begin
        w_grant    = w_cand;
        w_conflict = 1'b0;
        if (w_cand == 2'b11) begin
            w_conflict = 1'b1;
            if (r_rr_last == c_SRC_LSB) begin
                w_grant = 2'b01;
            end else begin
                w_grant = 2'b10;
            end
        end
    end

    assign w_any_grant = |w_grant;
    assign w_grant_src = w_grant[1] ? c_SRC_LSB : c_SRC_ALU;

    // Broadcast register, round-robin pointer and status counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cdb_valid    <= 1'b0;
            r_cdb_rob_id   <= '0;
            r_cdb_value    <= '0;
            r_cdb_src      <= c_SRC_ALU;
            r_rr_last      <= c_SRC_LSB;
            r_overflow     <= 1'b0;
            r_conflict_cnt <= '0;
        end else if (rob_clear) begin
            // Flush drops everything in flight but keeps the diagnostics.
            r_cdb_valid <= 1'b0;
            r_rr_last   <= c_SRC_LSB;
        end else if (rdy) begin
            r_cdb_valid <= w_any_grant;
            if (w_any_grant) begin
                r_cdb_rob_id <= w_cand_id[w_grant_src];
                r_cdb_value  <= w_cand_val[w_grant_src];
                r_cdb_src    <= w_grant_src;
                r_rr_last    <= w_grant_src;
            end
            if (|w_dropped) begin
                r_overflow <= 1'b1;
            end
            if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end

    assign alu_full     = w_full[0];
    assign lsb_full     = w_full[1];
    assign cdb_valid    = r_cdb_valid;
    assign cdb_rob_id   = r_cdb_rob_id;
    assign cdb_value    = r_cdb_value;
    assign cdb_src      = r_cdb_src;
    assign overflow     = r_overflow;
    assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Directed self-checking bench for cdb_arbiter: reset, bypass,
//            round-robin conflicts, backpressure/overflow, flush and rdy stall.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rob_clear;
    logic        alu_ready;
    logic [3:0]  alu_rob_id;
    logic [31:0] alu_value;
    logic        lsb_ready;
    logic [3:0]  lsb_rob_id;
    logic [31:0] lsb_value;
    logic        alu_full;
    logic        lsb_full;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_id;
    logic [31:0] cdb_value;
    logic        cdb_src;
    logic        overflow;
    logic [15:0] conflict_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    cdb_arbiter #(
        .ROB_ID_W   (4),
        .FIFO_DEPTH (4),
        .FIFO_PTR_W (2)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .rob_clear    (rob_clear),
        .alu_ready    (alu_ready),
        .alu_rob_id   (alu_rob_id),
        .alu_value    (alu_value),
        .lsb_ready    (lsb_ready),
        .lsb_rob_id   (lsb_rob_id),
        .lsb_value    (lsb_value),
        .alu_full     (alu_full),
        .lsb_full     (lsb_full),
        .cdb_valid    (cdb_valid),
        .cdb_rob_id   (cdb_rob_id),
        .cdb_value    (cdb_value),
        .cdb_src      (cdb_src),
        .overflow     (overflow),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    // Values carry the source in the upper half so ordering mix-ups show.
    function automatic logic [31:0] val_of(input logic src, input logic [3:0] tag);
        return (src ? 32'h5555_0000 : 32'hAAAA_0000) | {28'h0, tag};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic [3:0] at, input logic l, input logic [3:0] lt);
        alu_ready  = a;
        alu_rob_id = at;
        alu_value  = val_of(1'b0, at);
        lsb_ready  = l;
        lsb_rob_id = lt;
        lsb_value  = val_of(1'b1, lt);
    endtask

    task automatic do_reset();
        drive(1'b0, 4'h0, 1'b0, 4'h0);
        rob_clear = 1'b0;
        rdy       = 1'b1;
        rst       = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Three conflicting cycles: CDB shows 1, 9, 2; queued ALU 3, LSB 10, 11.
    task automatic prime_queue();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'(k + 1), 1'b1, 4'(k + 9));
            step();
        end
        drive(1'b0, 4'h0, 1'b0, 4'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rdy = 1'b1;
        rob_clear = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 4'h0);
        step();
        n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", cdb_valid); end
        n_checks++; if (cdb_rob_id !== 4'h0 || cdb_value !== 32'h0 || cdb_src !== 1'b0) begin n_fail++; $display("FAIL reset_payload: got id=%h val=%h src=%b want 0/0/0", cdb_rob_id, cdb_value, cdb_src); end
        n_checks++; if (overflow !== 1'b0 || conflict_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_status: got ovf=%b cnt=%0d want 0/0", overflow, conflict_cnt); end
        rst = 1'b0;
        // Build traffic leaving two entries in each FIFO.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'(k + 1), 1'b1, 4'(k + 9));
            step();
        end
        drive(1'b0, 4'h0, 1'b0, 4'h0);
        rst = 1'b1;
        #1;
        n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b want 0", cdb_valid); end
        n_checks++; if (alu_full !== 1'b0 || lsb_full !== 1'b0) begin n_fail++; $display("FAIL midreset_full: got %b/%b want 0/0", alu_full, lsb_full); end
        n_checks++; if (conflict_cnt !== 16'h0 || cdb_rob_id !== 4'h0) begin n_fail++; $display("FAIL midreset_cnt: got cnt=%0d id=%h want 0/0", conflict_cnt, cdb_rob_id); end
        #2;
        rst = 1'b0;
        step();
        n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_drained: got valid %b want 0", cdb_valid); end
        alu_ready  = 1'b1;
        alu_rob_id = 4'h6;
        alu_value  = 32'h0000_ABCD;
        step();
        alu_ready = 1'b0;
        n_checks++; if (cdb_valid !== 1'b1 || cdb_rob_id !== 4'h6 || cdb_value !== 32'h0000_ABCD || cdb_src !== 1'b0) begin n_fail++; $display("FAIL postreset_push: got v=%b id=%h val=%h src=%b want 1/6/0000abcd/0", cdb_valid, cdb_rob_id, cdb_value, cdb_src); end
    endtask

    task automatic test_bypass();
        do_reset();
        alu_ready  = 1'b1;
        alu_rob_id = 4'h5;
        alu_value  = 32'h0000_1234;
        step();
        alu_ready = 1'b0;
        n_checks++; if (cdb_valid !== 1'b1 || cdb_rob_id !== 4'h5 || cdb_value !== 32'h0000_1234 || cdb_src !== 1'b0) begin n_fail++; $display("FAIL bypass_out: got v=%b id=%h val=%h src=%b want 1/5/00001234/0", cdb_valid, cdb_rob_id, cdb_value, cdb_src); end
        step();
        n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_fifo_empty: got valid %b want 0", cdb_valid); end
        n_checks++; if (cdb_rob_id !== 4'h5 || cdb_value !== 32'h0000_1234) begin n_fail++; $display("FAIL bypass_hold: got id=%h val=%h want 5/00001234", cdb_rob_id, cdb_value); end
    endtask

    task automatic test_conflict_rr();
        logic       esrc;
        logic [3:0] etag;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c < 4) drive(1'b1, 4'(c + 1), 1'b1, 4'(c + 9));
            else       drive(1'b0, 4'h0, 1'b0, 4'h0);
            step();
            esrc = c[0];
            etag = esrc ? 4'(c / 2 + 9) : 4'(c / 2 + 1);
            n_checks++;
            if (cdb_valid !== 1'b1 || cdb_rob_id !== etag || cdb_src !== esrc || cdb_value !== val_of(esrc, etag)) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got v=%b id=%h src=%b val=%h want 1/%h/%b/%h", c, cdb_valid, cdb_rob_id, cdb_src, cdb_value, etag, esrc, val_of(esrc, etag));
            end
        end
        n_checks++; if (conflict_cnt !== 16'd7) begin n_fail++; $display("FAIL rr_conflicts: got %0d want 7", conflict_cnt); end
        step();
        n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drained: got valid %b want 0", cdb_valid); end
    endtask

    task automatic test_backpressure();
        logic       esrc;
        logic [3:0] etag;
        do_reset();
        for (int c = 0; c < 17; c++) begin
            if (c <= 8) drive(1'b1, 4'(c), 1'b1, 4'(c));
            else        drive(1'b0, 4'h0, 1'b0, 4'h0);
            step();
            esrc = c[0];
            etag = 4'(c / 2);
            n_checks++;
            if (cdb_valid !== 1'b1 || cdb_rob_id !== etag || cdb_src !== esrc || cdb_value !== val_of(esrc, etag)) begin
                n_fail++;
                $display("FAIL bp_order[%0d]: got v=%b id=%h src=%b val=%h want 1/%h/%b/%h", c, cdb_valid, cdb_rob_id, cdb_src, cdb_value, etag, esrc, val_of(esrc, etag));
            end
            if (c == 3) begin
                n_checks++; if (lsb_full !== 1'b0) begin n_fail++; $display("FAIL bp_lsb_full_early: got %b want 0", lsb_full); end
            end
            if (c == 4) begin
                n_checks++; if (lsb_full !== 1'b1) begin n_fail++; $display("FAIL bp_lsb_full: got %b want 1", lsb_full); end
            end
            if (c == 7) begin
                n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_overflow_early: got %b want 0", overflow); end
            end
            if (c == 8) begin
                n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow: got %b want 1", overflow); end
            end
        end
        step();
        n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL bp_dropped_absent: got valid %b id=%h want 0", cdb_valid, cdb_rob_id); end
        n_checks++; if (conflict_cnt !== 16'd16 || overflow !== 1'b1) begin n_fail++; $display("FAIL bp_status: got cnt=%0d ovf=%b want 16/1", conflict_cnt, overflow); end
    endtask

    task automatic test_flush();
        do_reset();
        prime_queue();
        n_checks++; if (cdb_rob_id !== 4'h2 || cdb_src !== 1'b0) begin n_fail++; $display("FAIL flush_prime: got id=%h src=%b want 2/0", cdb_rob_id, cdb_src); end
        rob_clear = 1'b1;
        drive(1'b1, 4'h4, 1'b0, 4'h0);
        step();
        rob_clear = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 4'h0);
        n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", cdb_valid); end
        n_checks++; if (conflict_cnt !== 16'd3 || alu_full !== 1'b0 || lsb_full !== 1'b0) begin n_fail++; $display("FAIL flush_status: got cnt=%0d full=%b/%b want 3/0/0", conflict_cnt, alu_full, lsb_full); end
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_quiet[%0d]: got valid %b id=%h want 0", c, cdb_valid, cdb_rob_id); end
        end
        drive(1'b1, 4'h5, 1'b1, 4'hC);
        step();
        drive(1'b0, 4'h0, 1'b0, 4'h0);
        n_checks++; if (cdb_valid !== 1'b1 || cdb_rob_id !== 4'h5 || cdb_src !== 1'b0) begin n_fail++; $display("FAIL flush_rr_alu: got v=%b id=%h src=%b want 1/5/0", cdb_valid, cdb_rob_id, cdb_src); end
        n_checks++; if (conflict_cnt !== 16'd4) begin n_fail++; $display("FAIL flush_cnt: got %0d want 4", conflict_cnt); end
        step();
        n_checks++; if (cdb_valid !== 1'b1 || cdb_rob_id !== 4'hC || cdb_src !== 1'b1) begin n_fail++; $display("FAIL flush_lsb_next: got v=%b id=%h src=%b want 1/c/1", cdb_valid, cdb_rob_id, cdb_src); end
    endtask

    task automatic test_rdy_stall();
        logic [3:0] etag [3];
        logic       esrc [3];
        etag = '{4'hA, 4'h3, 4'hB};
        esrc = '{1'b1, 1'b0, 1'b1};
        do_reset();
        prime_queue();
        rdy = 1'b0;
        drive(1'b1, 4'h7, 1'b1, 4'hD);
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (cdb_valid !== 1'b1 || cdb_rob_id !== 4'h2 || cdb_src !== 1'b0 || conflict_cnt !== 16'd3 || alu_full !== 1'b0 || lsb_full !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%b id=%h src=%b cnt=%0d full=%b/%b want 1/2/0/3/0/0", c, cdb_valid, cdb_rob_id, cdb_src, conflict_cnt, alu_full, lsb_full);
            end
        end
        rdy = 1'b1;
        drive(1'b0, 4'h0, 1'b0, 4'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (cdb_valid !== 1'b1 || cdb_rob_id !== etag[c] || cdb_src !== esrc[c] || cdb_value !== val_of(esrc[c], etag[c])) begin
                n_fail++;
                $display("FAIL stall_resume[%0d]: got v=%b id=%h src=%b val=%h want 1/%h/%b", c, cdb_valid, cdb_rob_id, cdb_src, cdb_value, etag[c], esrc[c]);
            end
        end
        step();
        n_checks++; if (cdb_valid !== 1'b0 || conflict_cnt !== 16'd5) begin n_fail++; $display("FAIL stall_end: got v=%b cnt=%0d want 0/5", cdb_valid, conflict_cnt); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_conflict_rr();
        test_backpressure();
        test_flush();
        test_rdy_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
